sevenseg_scan: RTL and testbench

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

---
 rtl/sevenseg_pkg.sv | 21 ++
 rtl/sevenseg_timer.sv | 77 +++++++
 rtl/sevenseg_scan.sv | 121 ++++++++++++
 tb/tb_sevenseg_scan.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// sevenseg_pkg : shared constants and helpers for the seven-segment scanner
// Rev 1.0
// ============================================================================
package sevenseg_pkg;

  localparam int SEG_W   = 8;
  localparam int DOT_BIT = 7;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_timer.sv
`default_nettype none
// ============================================================================
// sevenseg_timer : slot/digit counters, frame boundary, blink phase, PWM phase
// Rev 1.0
// ============================================================================
module sevenseg_timer
  import sevenseg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SLOT_CYCLES  = 1024,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64,
  localparam int DI_W        = clog2(DIGITS)
) (
  input  logic                clk_sys_i,
  input  logic                rst_n_i,
  output logic [DI_W-1:0]     di_o,
  output logic [BRIGHT_W-1:0] ph_o,
  output logic                boundary_o,
  output logic                bp_o
);

  localparam int SC_W = clog2(SLOT_CYCLES);
  localparam int BC_W = clog2(BLINK_FRAMES) + 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SLOT_CYCLES - 1);
  localparam logic [DI_W-1:0] DI_LAST = DI_W'(DIGITS - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

  logic [SC_W-1:0] sc_q, sc_d;
  logic [DI_W-1:0] di_q, di_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic            bp_q, bp_d;
  logic            sc_wrap;
  logic            boundary;

  always_comb begin
    sc_wrap  = (sc_q == SC_LAST);
    boundary = sc_wrap && (di_q == DI_LAST);
    sc_d     = sc_wrap ? '0 : sc_q + SC_W'(1);
    di_d     = di_q;
    bc_d     = bc_q;
    bp_d     = bp_q;
    if (sc_wrap) begin
      di_d = (di_q == DI_LAST) ? '0 : di_q + DI_W'(1);
    end
    // bp = 1 means visible; it flips once every BLINK_FRAMES boundaries
    if (boundary) begin
      if (bc_q == BC_LAST) begin
        bc_d = '0;
        bp_d = ~bp_q;
      end else begin
        bc_d = bc_q + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sc_q <= '0;
      di_q <= '0;
      bc_q <= '0;
      bp_q <= 1'b1;
    end else begin
      sc_q <= sc_d;
      di_q <= di_d;
      bc_q <= bc_d;
      bp_q <= bp_d;
    end
  end

  assign di_o       = di_q;
  assign ph_o       = sc_q[SC_W-1 -: BRIGHT_W];
  assign boundary_o = boundary;
  assign bp_o       = bp_q;

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
// sevenseg_scan : multiplexed seven-segment driver with shadowed display set
// Rev 1.0
// ============================================================================
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SLOT_CYCLES  = 1024,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic [SEG_W*DIGITS-1:0] digs_i,
  input  logic [DIGITS-1:0]       dots_i,
  input  logic [DIGITS-1:0]       blank_i,
  input  logic [DIGITS-1:0]       blink_i,
  input  logic [BRIGHT_W-1:0]     bright_i,
  input  logic                    load_i,
  output logic                    pending_o,
  output logic [SEG_W-1:0]        seg_o,
  output logic [DIGITS-1:0]       dig_o,
  output logic                    frame_o
);

  localparam int DI_W = clog2(DIGITS);

  typedef struct packed {
    logic [SEG_W*DIGITS-1:0] digs;
    logic [DIGITS-1:0]       dots;
    logic [DIGITS-1:0]       blank;
    logic [DIGITS-1:0]       blink;
    logic [BRIGHT_W-1:0]     bright;
  } cfg_t;

  logic [DI_W-1:0]     di;
  logic [BRIGHT_W-1:0] ph;
  logic                boundary;
  logic                bp;

  cfg_t              in_cfg;
  cfg_t              shadow_q, shadow_d;
  cfg_t              active_q, active_d;
  logic              pending_q, pending_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic              frame_q;
  logic [SEG_W-1:0]  sel_seg;
  logic              lit;

  sevenseg_timer #(
    .DIGITS      (DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .BRIGHT_W    (BRIGHT_W),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .di_o      (di),
    .ph_o      (ph),
    .boundary_o(boundary),
    .bp_o      (bp)
  );

  always_comb begin
    in_cfg    = '{digs: digs_i, dots: dots_i, blank: blank_i,
                  blink: blink_i, bright: bright_i};
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load_i) shadow_d = in_cfg;
    // a load coinciding with the boundary skips the shadow stage entirely
    if (boundary) begin
      pending_d = 1'b0;
      if (load_i)         active_d = in_cfg;
      else if (pending_q) active_d = shadow_q;
    end else if (load_i) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    sel_seg = active_q.digs[SEG_W*di +: SEG_W];
    // phase 0 stays dark so digit changes never ghost
    lit     = (ph != '0) && (ph <= active_q.bright) && !active_q.blank[di]
              && !(active_q.blink[di] && !bp);
    seg_d   = '0;
    dig_d   = '0;
    if (lit) begin
      seg_d = sel_seg | (SEG_W'(active_q.dots[di]) << DOT_BIT);
      dig_d = DIGITS'(1) << di;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      dig_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      frame_q   <= boundary;
    end
  end

  assign pending_o = pending_q;
  assign seg_o     = seg_q;
  assign dig_o     = dig_q;
  assign frame_o   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// tb_sevenseg_scan : directed bench for sevenseg_scan (4 digits, 16-cycle slots)
// Rev 1.0
// ============================================================================
module tb_sevenseg_scan;

  localparam int DIGITS = 4;
  localparam int SLOT   = 16;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] digs = '0;
  logic [3:0]  dots = '0, blank = '0, blink = '0;
  logic [1:0]  bright = '0;
  logic        load = 1'b0;
  logic        pending;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame;

  sevenseg_scan #(
    .DIGITS(4), .SLOT_CYCLES(16), .BRIGHT_W(2), .BLINK_FRAMES(2)
  ) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .digs_i(digs), .dots_i(dots),
    .blank_i(blank), .blink_i(blink), .bright_i(bright), .load_i(load),
    .pending_o(pending), .seg_o(seg), .dig_o(dig), .frame_o(frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // per-frame observations
  int         cnt[4];
  logic [7:0] segv[4];
  int         fsc[4];
  int         posbad, fbad;
  logic       pend_seen, pend_end;

  // At negedge j the outputs show counter state j-1 of the frame (di, sc).
  task automatic run_frame(input int la, input logic [31:0] va,
                           input int lb, input logic [31:0] vb);
    int s, d, sc;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0; segv[k] = '0; fsc[k] = -1;
    end
    posbad = 0; fbad = 0; pend_seen = 1'b0; pend_end = 1'b0;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      s = j - 1; d = s / SLOT; sc = s % SLOT;
      if (dig != 4'b0) begin
        if (dig != 4'(1 << d) || sc < 4) posbad++;
        if (cnt[d] == 0) begin
          fsc[d] = sc; segv[d] = seg;
        end else if (seg != segv[d]) begin
          posbad++;
        end
        cnt[d]++;
      end else if (seg != 8'h0) begin
        posbad++;
      end
      if (frame != (j == FRAME)) fbad++;
      if (pending) pend_seen = 1'b1;
      if (j == FRAME) pend_end = pending;
      load = (j == la) || (j == lb);
      if (j == la) digs = va;
      if (j == lb) digs = vb;
    end
  endtask

  typedef struct {
    logic [31:0] digs;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic [1:0]  bright;
    logic [31:0] eseg;   // expected seg, digit k at [8k+:8]
    logic [31:0] ecnt;   // expected lit cycles per frame, digit k at [8k+:8]
  } vec_t;

  vec_t vt[5];
  int   blink_exp[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h3F065B4F, 4'b0000, 4'b0000, 2'd3, 32'h3F065B4F, 32'h0C0C0C0C};
    vt[1] = '{32'h6D667F07, 4'b0101, 4'b0000, 2'd1, 32'h6DE67F87, 32'h04040404};
    vt[2] = '{32'h00FF1234, 4'b0000, 4'b1000, 2'd2, 32'h00FF1234, 32'h00080808};
    vt[3] = '{32'h11223344, 4'b1111, 4'b0000, 2'd0, 32'h00000000, 32'h00000000};
    vt[4] = '{32'hA5B6C7D8, 4'b0010, 4'b0001, 2'd3, 32'hA5B6C7D8, 32'h0C0C0C00};
    blink_exp = '{0, 12, 0, 0, 12, 12};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 0);
    check("rst_dig", 32'(dig), 0);
    check("rst_frame", 32'(frame), 0);
    check("rst_pending", 32'(pending), 0);
    rst_n = 1'b1;

    // frame 0: load on the boundary cycle, blink digit 1
    blink = 4'b0010; bright = 2'd3;
    run_frame(63, 32'h3F065B4F, -1, '0);
    check("f0_pend_never", 32'(pend_seen), 0);
    check("f0_dark", 32'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 0);
    check("f0_frame", 32'(fbad), 0);
    for (int f = 1; f <= 5; f++) begin
      run_frame(-1, '0, -1, '0);
      check($sformatf("blink_f%0d_d1", f), 32'(cnt[1]), 32'(blink_exp[f]));
      check($sformatf("blink_f%0d_d0", f), 32'(cnt[0]), 12);
      check($sformatf("blink_f%0d_pos", f), 32'(posbad + fbad), 0);
      if (f == 1) begin
        check("bypass_d0_seg", 32'(segv[0]), 32'h4F);
        check("bypass_d0_first", 32'(fsc[0]), 4);
      end
    end

    // table vectors: mid-frame load, then one frame of the new set
    blink = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      dots = vt[i].dots; blank = vt[i].blank; bright = vt[i].bright;
      run_frame(10, vt[i].digs, -1, '0);
      check($sformatf("v%0d_pend_rise", i), 32'(pend_seen), 1);
      check($sformatf("v%0d_pend_clear", i), 32'(pend_end), 0);
      check($sformatf("v%0d_ldframe_pos", i), 32'(posbad + fbad), 0);
      if (i > 0) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("v%0d_old_cnt%0d", i, k), 32'(cnt[k]), 32'(vt[i-1].ecnt[8*k +: 8]));
          if (vt[i-1].ecnt[8*k +: 8] != 8'd0)
            check($sformatf("v%0d_old_seg%0d", i, k), 32'(segv[k]), 32'(vt[i-1].eseg[8*k +: 8]));
        end
      end
      run_frame(-1, '0, -1, '0);
      check($sformatf("v%0d_pos", i), 32'(posbad + fbad), 0);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("v%0d_cnt%0d", i, k), 32'(cnt[k]), 32'(vt[i].ecnt[8*k +: 8]));
        if (vt[i].ecnt[8*k +: 8] != 8'd0) begin
          check($sformatf("v%0d_seg%0d", i, k), 32'(segv[k]), 32'(vt[i].eseg[8*k +: 8]));
          check($sformatf("v%0d_first%0d", i, k), 32'(fsc[k]), 4);
        end
      end
    end

    // two loads in one frame: the later one wins
    dots = '0; blank = '0; bright = 2'd3;
    run_frame(10, 32'h01020304, 30, 32'h0A0B0C0D);
    run_frame(-1, '0, -1, '0);
    check("two_loads", {segv[3], segv[2], segv[1], segv[0]}, 32'h0A0B0C0D);

    // boundary-cycle load outside reset context
    run_frame(63, 32'h40404040, -1, '0);
    check("bnd_pend_never", 32'(pend_seen), 0);
    run_frame(-1, '0, -1, '0);
    check("bnd_seg2", 32'(segv[2]), 32'h40);

    // reset at di=2, sc=7 with data pending
    for (int j = 1; j <= 39; j++) begin
      @(negedge clk);
      load = (j == 5);
      if (j == 5) digs = 32'hFFFFFFFF;
    end
    check("mid_pending", 32'(pending), 1);
    check("mid_dig_before", 32'(dig), 32'b0100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_seg", 32'(seg), 0);
    check("mid_rst_dig", 32'(dig), 0);
    check("mid_rst_pending", 32'(pending), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(-1, '0, -1, '0);
    check("post_f0_dark", 32'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 0);
    check("post_f0_frame", 32'(fbad), 0);
    check("post_f0_pend", 32'(pend_seen), 0);
    run_frame(63, 32'h0000007F, -1, '0);
    check("post_f1_discard", 32'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 0);
    run_frame(-1, '0, -1, '0);
    check("post_f2_first", 32'(fsc[0]), 4);
    check("post_f2_seg", 32'(segv[0]), 32'h7F);
    check("post_f2_cnt", 32'(cnt[0]), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
